// File: rtl/vend_ctrl_param_if.sv
// Coin/change bus of the parametrised vending controller.
// The master drives coins and acks; the slave reports vend/change/credit.
interface vend_ctrl_param_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic [1:0]          coin_sel;
    logic                cancel;
    logic                change_ack;
    logic                guffin_out;
    logic                quarter_out;
    logic                halfDollar_out;
    logic                coin_reject;
    logic                busy;
    logic [1:0]          state_code;
    logic [CREDIT_W-1:0] credit_q;
    logic [3:0]          cred_dollar;
    logic [3:0]          cred_tens;
    logic [3:0]          cred_ones;

    modport master (
        output coin_valid, coin_sel, cancel, change_ack,
        input  guffin_out, quarter_out, halfDollar_out, coin_reject,
        input  busy, state_code, credit_q,
        input  cred_dollar, cred_tens, cred_ones
    );

    modport slave (
        input  coin_valid, coin_sel, cancel, change_ack,
        output guffin_out, quarter_out, halfDollar_out, coin_reject,
        output busy, state_code, credit_q,
        output cred_dollar, cred_tens, cred_ones
    );
endinterface

// File: rtl/vend_ctrl_param.sv
// Vending controller with a binary quarter-unit credit counter,
// parametrised price, cancel refund and acked one-coin-at-a-time change.
module vend_ctrl_param #(
    parameter int PRICE_Q      = 6,
    parameter int MAX_CREDIT_Q = 12,
    parameter int CREDIT_W     = 4
) (
    input  logic              CLK,
    input  logic              RES,
    vend_ctrl_param_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_VEND    = 2'b10,
        S_CHANGE  = 2'b11
    } state_t;

    localparam int SW = CREDIT_W + 1;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_guffin;
    logic                r_quarter;
    logic                r_half;
    logic                r_reject;

    logic [SW-1:0]       w_coin_val;
    logic [SW-1:0]       w_sum;
    logic                w_fits;
    logic                w_open;
    logic                w_accept;
    logic                w_reject;
    logic                w_cancel;
    logic [CREDIT_W-1:0] w_rem;
    logic [CREDIT_W-1:0] w_left;
    logic [CREDIT_W-1:0] w_div;
    logic [3:0]          w_tens;
    logic [3:0]          w_ones;

    // Coin code to quarter value; the invalid code is worth nothing.
    always_comb begin
        w_coin_val = '0;
        unique case (bus.coin_sel)
            2'b00:   w_coin_val = SW'(1);
            2'b01:   w_coin_val = SW'(2);
            2'b10:   w_coin_val = SW'(4);
            default: w_coin_val = '0;
        endcase
    end

    // Sum is one bit wider so an overflowing coin is still seen as too big.
    assign w_sum    = {1'b0, r_credit} + w_coin_val;
    assign w_fits   = (w_sum <= SW'(MAX_CREDIT_Q));
    assign w_open   = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_accept = bus.coin_valid && w_open && !bus.cancel
                      && (bus.coin_sel != 2'b11) && w_fits;
    assign w_reject = bus.coin_valid && !w_accept;
    assign w_cancel = bus.cancel && (r_state == S_COLLECT);
    assign w_rem    = r_credit - CREDIT_W'(PRICE_Q);
    assign w_left   = r_credit - (r_half ? CREDIT_W'(2) : CREDIT_W'(1));

    // Main FSM with registered pulse and change-request outputs.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state   <= S_IDLE;
            r_credit  <= '0;
            r_guffin  <= 1'b0;
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            r_reject <= w_reject;
            r_guffin <= 1'b0;
            unique case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_cancel) begin
                        r_state   <= S_CHANGE;
                        r_half    <= (r_credit >= CREDIT_W'(2));
                        r_quarter <= (r_credit == CREDIT_W'(1));
                    end else if (w_accept) begin
                        r_credit <= w_sum[CREDIT_W-1:0];
                        if (w_sum >= SW'(PRICE_Q)) begin
                            r_state  <= S_VEND;
                            r_guffin <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_VEND: begin
                    r_credit <= w_rem;
                    if (w_rem != '0) begin
                        r_state   <= S_CHANGE;
                        r_half    <= (w_rem >= CREDIT_W'(2));
                        r_quarter <= (w_rem == CREDIT_W'(1));
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CHANGE: begin
                    if (r_half || r_quarter) begin
                        if (bus.change_ack) begin
                            r_credit  <= w_left;
                            r_half    <= 1'b0;
                            r_quarter <= 1'b0;
                            if (w_left == '0) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (r_credit == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_half    <= (r_credit >= CREDIT_W'(2));
                        r_quarter <= (r_credit == CREDIT_W'(1));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Cents digits of the credit display from the quarter remainder.
    always_comb begin
        w_tens = 4'd0;
        w_ones = 4'd0;
        unique case (r_credit[1:0])
            2'd0: begin w_tens = 4'd0; w_ones = 4'd0; end
            2'd1: begin w_tens = 4'd2; w_ones = 4'd5; end
            2'd2: begin w_tens = 4'd5; w_ones = 4'd0; end
            2'd3: begin w_tens = 4'd7; w_ones = 4'd5; end
            default: begin w_tens = 4'd0; w_ones = 4'd0; end
        endcase
    end

    assign w_div = r_credit >> 2;

    assign bus.guffin_out     = r_guffin;
    assign bus.quarter_out    = r_quarter;
    assign bus.halfDollar_out = r_half;
    assign bus.coin_reject    = r_reject;
    assign bus.busy           = r_state[1];
    assign bus.state_code     = r_state;
    assign bus.credit_q       = r_credit;
    assign bus.cred_dollar    = 4'(w_div);
    assign bus.cred_tens      = w_tens;
    assign bus.cred_ones      = w_ones;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: default-price unit plus an overflow unit
// (price 11, max credit 11); change coins go through a scoreboard queue.
module tb_vend_ctrl_param;
    logic CLK = 1'b0;
    logic RES = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];

    vend_ctrl_param_if #(.CREDIT_W(4)) ifa ();
    vend_ctrl_param_if #(.CREDIT_W(4)) ifb ();

    vend_ctrl_param #(.PRICE_Q(6), .MAX_CREDIT_Q(12), .CREDIT_W(4))
        u_a (.CLK(CLK), .RES(RES), .bus(ifa.slave));
    vend_ctrl_param #(.PRICE_Q(11), .MAX_CREDIT_Q(11), .CREDIT_W(4))
        u_b (.CLK(CLK), .RES(RES), .bus(ifb.slave));

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        ifa.coin_valid = 0; ifa.coin_sel = 0; ifa.cancel = 0; ifa.change_ack = 0;
        ifb.coin_valid = 0; ifb.coin_sel = 0; ifb.cancel = 0; ifb.change_ack = 0;
        RES = 1;
        @(negedge CLK);
        @(negedge CLK);
        RES = 0;
        exp_q.delete();
    endtask

    task automatic coin_a(input logic [1:0] sel);
        ifa.coin_sel = sel; ifa.coin_valid = 1;
        @(negedge CLK);
        ifa.coin_valid = 0;
    endtask

    task automatic coin_b(input logic [1:0] sel);
        ifb.coin_sel = sel; ifb.coin_valid = 1;
        @(negedge CLK);
        ifb.coin_valid = 0;
    endtask

    task automatic cancel_a();
        ifa.cancel = 1;
        @(negedge CLK);
        ifa.cancel = 0;
    endtask

    // Acks every change request on unit A, popping the expected coin each time.
    task automatic pay_out_a(input string nm);
        int  n = 0;
        bit  done = 0;
        int  kind;
        int  e;
        while (!done && n < 40) begin
            if (ifa.state_code == 2'b00) begin
                done = 1;
            end else if (ifa.halfDollar_out || ifa.quarter_out) begin
                kind = ifa.halfDollar_out ? 2 : 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected coin: got %0d, none queued", nm, kind);
                end else begin
                    e = exp_q.pop_front();
                    if (kind !== e) begin
                        errors++;
                        $display("FAIL %s coin: got %0d want %0d", nm, kind, e);
                    end
                end
                checks++;
                if ((ifa.halfDollar_out && ifa.quarter_out) || ifa.guffin_out) begin
                    errors++;
                    $display("FAIL %s exclusive: half=%b q=%b g=%b want one", nm,
                             ifa.halfDollar_out, ifa.quarter_out, ifa.guffin_out);
                end
                ifa.change_ack = 1;
                @(negedge CLK);
                ifa.change_ack = 0;
                checks++;
                if (ifa.halfDollar_out || ifa.quarter_out) begin
                    errors++;
                    $display("FAIL %s gap: req still high after ack, want 0", nm);
                end
            end else begin
                @(negedge CLK);
            end
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: state=%0d want 0", nm, ifa.state_code);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: %0d coins unpaid, want 0", nm, exp_q.size());
        end
        checks++;
        if (ifa.credit_q !== 4'd0) begin
            errors++;
            $display("FAIL %s credit: got %0d want 0", nm, ifa.credit_q);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ifa.state_code, ifa.credit_q, ifa.guffin_out, ifa.quarter_out,
             ifa.halfDollar_out, ifa.coin_reject, ifa.busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset: st=%0d cr=%0d outs=%b%b%b%b%b want all 0",
                     ifa.state_code, ifa.credit_q, ifa.guffin_out, ifa.quarter_out,
                     ifa.halfDollar_out, ifa.coin_reject, ifa.busy);
        end
        checks++;
        if ({ifa.cred_dollar, ifa.cred_tens, ifa.cred_ones} !== 12'h000) begin
            errors++;
            $display("FAIL reset_bcd: got %h want 000",
                     {ifa.cred_dollar, ifa.cred_tens, ifa.cred_ones});
        end
    endtask

    task automatic test_exact_price();
        do_reset();
        coin_a(2'b00);
        checks++;
        if (ifa.credit_q !== 4'd1 || ifa.state_code !== 2'b01) begin
            errors++;
            $display("FAIL exact_q: cr=%0d st=%0d want 1/1", ifa.credit_q, ifa.state_code);
        end
        coin_a(2'b01);
        checks++;
        if (ifa.credit_q !== 4'd3 || ifa.state_code !== 2'b01) begin
            errors++;
            $display("FAIL exact_h: cr=%0d st=%0d want 3/1", ifa.credit_q, ifa.state_code);
        end
        coin_a(2'b10);
        exp_q.push_back(1);
        checks++;
        if (ifa.credit_q !== 4'd7 || ifa.state_code !== 2'b10
            || ifa.guffin_out !== 1'b1 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL exact_vend: cr=%0d st=%0d g=%b busy=%b want 7/2/1/1",
                     ifa.credit_q, ifa.state_code, ifa.guffin_out, ifa.busy);
        end
        @(negedge CLK);
        checks++;
        if (ifa.credit_q !== 4'd1 || ifa.state_code !== 2'b11 || ifa.guffin_out !== 1'b0) begin
            errors++;
            $display("FAIL exact_rem: cr=%0d st=%0d g=%b want 1/3/0",
                     ifa.credit_q, ifa.state_code, ifa.guffin_out);
        end
        pay_out_a("exact");
    endtask

    task automatic test_cancel();
        int e;
        do_reset();
        coin_a(2'b01);
        coin_a(2'b00);
        cancel_a();
        exp_q.push_back(2);
        exp_q.push_back(1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ifa.halfDollar_out !== 1'b1 || ifa.quarter_out !== 1'b0
                || ifa.credit_q !== 4'd3 || ifa.state_code !== 2'b11) begin
                errors++;
                $display("FAIL cancel_hold%0d: h=%b q=%b cr=%0d st=%0d want 1/0/3/3", i,
                         ifa.halfDollar_out, ifa.quarter_out, ifa.credit_q, ifa.state_code);
            end
            if (i < 2) @(negedge CLK);
        end
        e = exp_q.pop_front();
        checks++;
        if (e !== 2) begin
            errors++;
            $display("FAIL cancel_first: got 2 want %0d", e);
        end
        ifa.change_ack = 1;
        @(negedge CLK);
        checks++;
        if (ifa.halfDollar_out !== 1'b0 || ifa.quarter_out !== 1'b0
            || ifa.credit_q !== 4'd1 || ifa.state_code !== 2'b11) begin
            errors++;
            $display("FAIL cancel_gap: h=%b q=%b cr=%0d st=%0d want 0/0/1/3",
                     ifa.halfDollar_out, ifa.quarter_out, ifa.credit_q, ifa.state_code);
        end
        @(negedge CLK);
        ifa.change_ack = 0;
        checks++;
        if (ifa.quarter_out !== 1'b1 || ifa.halfDollar_out !== 1'b0 || ifa.credit_q !== 4'd1) begin
            errors++;
            $display("FAIL cancel_q: q=%b h=%b cr=%0d want 1/0/1",
                     ifa.quarter_out, ifa.halfDollar_out, ifa.credit_q);
        end
        pay_out_a("cancel");
    endtask

    task automatic test_collision();
        do_reset();
        coin_a(2'b01);
        ifa.cancel = 1; ifa.coin_valid = 1; ifa.coin_sel = 2'b00;
        @(negedge CLK);
        ifa.cancel = 0; ifa.coin_valid = 0;
        exp_q.push_back(2);
        checks++;
        if (ifa.coin_reject !== 1'b1 || ifa.credit_q !== 4'd2 || ifa.state_code !== 2'b11) begin
            errors++;
            $display("FAIL collide: rej=%b cr=%0d st=%0d want 1/2/3",
                     ifa.coin_reject, ifa.credit_q, ifa.state_code);
        end
        pay_out_a("collide");
    endtask

    task automatic test_mid_reset();
        do_reset();
        coin_a(2'b01);
        coin_a(2'b00);
        cancel_a();
        checks++;
        if (ifa.halfDollar_out !== 1'b1 || ifa.credit_q !== 4'd3) begin
            errors++;
            $display("FAIL midrst_pre: h=%b cr=%0d want 1/3", ifa.halfDollar_out, ifa.credit_q);
        end
        RES = 1;
        @(negedge CLK);
        RES = 0;
        checks++;
        if ({ifa.state_code, ifa.credit_q, ifa.guffin_out, ifa.quarter_out,
             ifa.halfDollar_out, ifa.coin_reject, ifa.busy} !== 11'd0) begin
            errors++;
            $display("FAIL midrst: st=%0d cr=%0d h=%b q=%b want all 0",
                     ifa.state_code, ifa.credit_q, ifa.halfDollar_out, ifa.quarter_out);
        end
    endtask

    task automatic test_display_vend();
        do_reset();
        coin_a(2'b11);
        checks++;
        if (ifa.coin_reject !== 1'b1 || ifa.credit_q !== 4'd0 || ifa.state_code !== 2'b00) begin
            errors++;
            $display("FAIL badcode: rej=%b cr=%0d st=%0d want 1/0/0",
                     ifa.coin_reject, ifa.credit_q, ifa.state_code);
        end
        coin_a(2'b00);
        coin_a(2'b10);
        checks++;
        if ({ifa.cred_dollar, ifa.cred_tens, ifa.cred_ones} !== 12'h125
            || ifa.coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL disp5: got %h rej=%b want 125/0",
                     {ifa.cred_dollar, ifa.cred_tens, ifa.cred_ones}, ifa.coin_reject);
        end
        coin_a(2'b01);
        checks++;
        if ({ifa.cred_dollar, ifa.cred_tens, ifa.cred_ones} !== 12'h175
            || ifa.state_code !== 2'b10) begin
            errors++;
            $display("FAIL disp7: got %h st=%0d want 175/2",
                     {ifa.cred_dollar, ifa.cred_tens, ifa.cred_ones}, ifa.state_code);
        end
        coin_a(2'b00);
        exp_q.push_back(1);
        checks++;
        if (ifa.coin_reject !== 1'b1 || ifa.credit_q !== 4'd1 || ifa.state_code !== 2'b11) begin
            errors++;
            $display("FAIL vendcoin: rej=%b cr=%0d st=%0d want 1/1/3",
                     ifa.coin_reject, ifa.credit_q, ifa.state_code);
        end
        pay_out_a("vendcoin");
    endtask

    task automatic test_overflow();
        do_reset();
        coin_b(2'b10);
        coin_b(2'b10);
        checks++;
        if (ifb.credit_q !== 4'd8 || ifb.state_code !== 2'b01) begin
            errors++;
            $display("FAIL ovf_8: cr=%0d st=%0d want 8/1", ifb.credit_q, ifb.state_code);
        end
        coin_b(2'b10);
        checks++;
        if (ifb.coin_reject !== 1'b1 || ifb.credit_q !== 4'd8 || ifb.state_code !== 2'b01
            || {ifb.cred_dollar, ifb.cred_tens, ifb.cred_ones} !== 12'h200) begin
            errors++;
            $display("FAIL ovf_rej: rej=%b cr=%0d st=%0d bcd=%h want 1/8/1/200",
                     ifb.coin_reject, ifb.credit_q, ifb.state_code,
                     {ifb.cred_dollar, ifb.cred_tens, ifb.cred_ones});
        end
        coin_b(2'b01);
        checks++;
        if (ifb.credit_q !== 4'd10 || ifb.coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL ovf_10: cr=%0d rej=%b want 10/0", ifb.credit_q, ifb.coin_reject);
        end
        coin_b(2'b00);
        checks++;
        if (ifb.credit_q !== 4'd11 || ifb.state_code !== 2'b10 || ifb.guffin_out !== 1'b1) begin
            errors++;
            $display("FAIL ovf_max: cr=%0d st=%0d g=%b want 11/2/1",
                     ifb.credit_q, ifb.state_code, ifb.guffin_out);
        end
        @(negedge CLK);
        checks++;
        if (ifb.credit_q !== 4'd0 || ifb.state_code !== 2'b00 || ifb.guffin_out !== 1'b0) begin
            errors++;
            $display("FAIL ovf_done: cr=%0d st=%0d g=%b want 0/0/0",
                     ifb.credit_q, ifb.state_code, ifb.guffin_out);
        end
    endtask

    initial begin
        ifa.coin_valid = 0; ifa.coin_sel = 0; ifa.cancel = 0; ifa.change_ack = 0;
        ifb.coin_valid = 0; ifb.coin_sel = 0; ifb.cancel = 0; ifb.change_ack = 0;
        @(negedge CLK);
        test_reset();
        test_exact_price();
        test_overflow();
        test_cancel();
        test_collision();
        test_mid_reset();
        test_display_vend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
